// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with two prioritised write ports,
// NRD combinational read ports, optional same-cycle write-to-read bypass and
// a sequenced bulk-clear engine that zeroes one entry per cycle.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we0,
  input  logic [ADDR_W-1:0]       waddr0,
  input  logic [DATA_W-1:0]       wdata0,
  input  logic                    we1,
  input  logic [ADDR_W-1:0]       waddr1,
  input  logic [DATA_W-1:0]       wdata1,
  input  logic [NRD*ADDR_W-1:0]   raddr,
  output logic [NRD*DATA_W-1:0]   rdata,
  input  logic                    clr_req,
  output logic                    clr_busy
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   clr_idx;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                wr0_ok;
  logic                wr1_ok;
  logic                byp_en;
  logic [ADDR_W-1:0]   ra;

  // A write to entry 0 is discarded when entry 0 is hardwired to zero; the
  // same qualified enables drive both the array and the bypass path so a
  // dropped write can never be forwarded.
  assign wr0_ok = we0 && !((ZERO_REG != 0) && (waddr0 == '0));
  assign wr1_ok = we1 && !((ZERO_REG != 0) && (waddr1 == '0));
  assign byp_en = (BYPASS != 0) && (state == IDLE);

  // Clear sequencer: IDLE waits for clr_req, CLEAR walks the index once
  // through every entry and returns to IDLE after the all-ones entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      clr_idx  <= '0;
      clr_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_req) begin
            state    <= CLEAR;
            clr_idx  <= '0;
            clr_busy <= 1'b1;
          end
        end
        CLEAR: begin
          if (clr_idx == {ADDR_W{1'b1}}) begin
            state    <= IDLE;
            clr_idx  <= '0;
            clr_busy <= 1'b0;
          end else begin
            clr_idx <= clr_idx + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          clr_idx  <= '0;
          clr_busy <= 1'b0;
        end
      endcase
    end
  end

  // Storage array: clear engine owns the array while running (writes are
  // dropped); otherwise port 1 is applied after port 0 so it wins on a tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i[ADDR_W-1:0]] <= '0;
      end
    end else if (state == CLEAR) begin
      mem[clr_idx] <= '0;
    end else begin
      if (wr0_ok) begin
        mem[waddr0] <= wdata0;
      end
      if (wr1_ok) begin
        mem[waddr1] <= wdata1;
      end
    end
  end

  // Read ports: zero register first, then bypass (port 1 before port 0),
  // then the stored entry.
  always_comb begin
    rdata = '0;
    ra    = '0;
    for (int k = 0; k < NRD; k++) begin
      ra = raddr[k*ADDR_W +: ADDR_W];
      if ((ZERO_REG != 0) && (ra == '0)) begin
        rdata[k*DATA_W +: DATA_W] = '0;
      end else if (byp_en && wr1_ok && (waddr1 == ra)) begin
        rdata[k*DATA_W +: DATA_W] = wdata1;
      end else if (byp_en && wr0_ok && (waddr0 == ra)) begin
        rdata[k*DATA_W +: DATA_W] = wdata0;
      end else begin
        rdata[k*DATA_W +: DATA_W] = mem[ra];
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed table-driven bench for regfile_mp (default
// parameters), plus hand-written sequences for the clear engine and reset.
module tb_regfile_mp;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NRD    = 2;

  logic                  clk;
  logic                  rst_n;
  logic                  we0;
  logic [ADDR_W-1:0]     waddr0;
  logic [DATA_W-1:0]     wdata0;
  logic                  we1;
  logic [ADDR_W-1:0]     waddr1;
  logic [DATA_W-1:0]     wdata1;
  logic [NRD*ADDR_W-1:0] raddr;
  logic [NRD*DATA_W-1:0] rdata;
  logic                  clr_req;
  logic                  clr_busy;

  int n_tests;
  int n_fail;

  regfile_mp #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NRD(NRD), .ZERO_REG(1), .BYPASS(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .raddr(raddr), .rdata(rdata),
    .clr_req(clr_req), .clr_busy(clr_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              we0;
    logic [ADDR_W-1:0] wa0;
    logic [DATA_W-1:0] wd0;
    logic              we1;
    logic [ADDR_W-1:0] wa1;
    logic [DATA_W-1:0] wd1;
    logic [ADDR_W-1:0] ra0;
    logic [ADDR_W-1:0] ra1;
    logic [DATA_W-1:0] exp0;
    logic [DATA_W-1:0] exp1;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    we0 = 1'b0; waddr0 = '0; wdata0 = '0;
    we1 = 1'b0; waddr1 = '0; wdata1 = '0;
    clr_req = 1'b0;
  endtask

  task automatic set_raddr(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
    raddr = {a1, a0};
  endtask

  // single write via port 0, then return just after the next negedge
  task automatic wr0(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    we0 = 1'b1; waddr0 = a; wdata0 = d;
    @(negedge clk);
    we0 = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    for (int a = 0; a < (1 << ADDR_W); a++) begin
      set_raddr(a[ADDR_W-1:0], 5'(31 - a));
      #1;
      check({name, "_p0"}, rdata[DATA_W-1:0], '0);
      check({name, "_p1"}, rdata[2*DATA_W-1:DATA_W], '0);
    end
  endtask

  int n;
  logic rst_done;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    idle_inputs();
    set_raddr('0, '0);
    rst_n = 1'b0;

    //            we0 wa0  wd0           we1 wa1  wd1           ra0  ra1  exp0          exp1
    vecs[0]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,        5'd0, 5'd1,  32'h0,        32'h0};
    vecs[1]  = '{1'b1, 5'd3, 32'hA5A5A5A5, 1'b0, 5'd0,  32'h0,        5'd3, 5'd3,  32'hA5A5A5A5, 32'hA5A5A5A5};
    vecs[2]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,        5'd3, 5'd0,  32'hA5A5A5A5, 32'h0};
    vecs[3]  = '{1'b1, 5'd7, 32'h11111111, 1'b1, 5'd7,  32'h22222222, 5'd7, 5'd7,  32'h22222222, 32'h22222222};
    vecs[4]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,        5'd7, 5'd7,  32'h22222222, 32'h22222222};
    vecs[5]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0,  32'hFFFFFFFF, 5'd0, 5'd3,  32'h0,        32'hA5A5A5A5};
    vecs[6]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,        5'd0, 5'd7,  32'h0,        32'h22222222};
    vecs[7]  = '{1'b1, 5'd9, 32'h99,       1'b1, 5'd10, 32'h1010,     5'd9, 5'd10, 32'h99,       32'h1010};
    vecs[8]  = '{1'b1, 5'd9, 32'h123,      1'b0, 5'd0,  32'h0,        5'd9, 5'd10, 32'h123,      32'h1010};
    vecs[9]  = '{1'b1, 5'd0, 32'hDEAD,     1'b1, 5'd12, 32'h12,       5'd0, 5'd12, 32'h0,        32'h12};
    vecs[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,        5'd9, 5'd12, 32'h123,      32'h12};

    // reset: all reads zero, engine idle
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_busy", {31'b0, clr_busy}, 32'h0);
    check_all_zero("rst_read");
    @(negedge clk);

    // table: write/bypass/priority/zero-register behaviour
    for (int i = 0; i < 11; i++) begin
      we0 = vecs[i].we0; waddr0 = vecs[i].wa0; wdata0 = vecs[i].wd0;
      we1 = vecs[i].we1; waddr1 = vecs[i].wa1; wdata1 = vecs[i].wd1;
      set_raddr(vecs[i].ra0, vecs[i].ra1);
      #1;
      check($sformatf("vec%0d_p0", i), rdata[DATA_W-1:0], vecs[i].exp0);
      check($sformatf("vec%0d_p1", i), rdata[2*DATA_W-1:DATA_W], vecs[i].exp1);
      @(negedge clk);
    end
    idle_inputs();

    // bulk clear: fill 1..31, clear, writes dropped and bypass off mid-clear
    for (int a = 1; a < 32; a++) wr0(a[ADDR_W-1:0], 32'(a));
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    n = 0;
    while (clr_busy === 1'b1 && n < 100) begin
      n++;
      if (n == 1) begin
        we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'h55;
        set_raddr(5'd5, 5'd31);
        #1;
        check("clr_nobypass", rdata[DATA_W-1:0], 32'd5);
        check("clr_stored31", rdata[2*DATA_W-1:DATA_W], 32'd31);
      end
      if (n == 2) begin
        we0 = 1'b0;
        clr_req = 1'b1;
        set_raddr(5'd5, 5'd0);
        #1;
        check("clr_wr_dropped", rdata[DATA_W-1:0], 32'd5);
      end
      if (n == 3) clr_req = 1'b0;
      if (n == 10) begin
        set_raddr(5'd20, 5'd8);
        #1;
        check("clr_pending20", rdata[DATA_W-1:0], 32'd20);
        check("clr_done8", rdata[2*DATA_W-1:DATA_W], 32'd0);
      end
      @(negedge clk);
    end
    check("clr_cycles", 32'(n), 32'd32);
    #1;
    check("clr_busy_end", {31'b0, clr_busy}, 32'h0);
    check_all_zero("clr_read");
    @(negedge clk);

    // reset mid-clear aborts immediately; a fresh clear runs full length
    wr0(5'd4, 32'h44);
    wr0(5'd30, 32'h30);
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    n = 0;
    rst_done = 1'b0;
    while (clr_busy === 1'b1 && n < 100 && !rst_done) begin
      n++;
      if (n == 10) begin
        set_raddr(5'd30, 5'd4);
        #1;
        check("abort_pre30", rdata[DATA_W-1:0], 32'h30);
        check("abort_pre4", rdata[2*DATA_W-1:DATA_W], 32'h0);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'b0, clr_busy}, 32'h0);
        check("abort_read30", rdata[DATA_W-1:0], 32'h0);
        #1;
        rst_n = 1'b1;
        rst_done = 1'b1;
      end
      @(negedge clk);
    end
    check("abort_reached", {31'b0, rst_done}, 32'h1);
    #1;
    check("abort_idle", {31'b0, clr_busy}, 32'h0);
    @(negedge clk);
    wr0(5'd6, 32'h66);
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    n = 0;
    while (clr_busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("reclr_cycles", 32'(n), 32'd32);
    set_raddr(5'd6, 5'd4);
    #1;
    check("reclr_read6", rdata[DATA_W-1:0], 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
